// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared opcodes, NOP encoding and fetch-state enum
package if_fetch_pkg;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    localparam logic [3:0] OP_LW  = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;
    localparam logic [3:0] OP_JR  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MISS     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALTED   = 2'd3
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction-memory read port plus IF/ID boundary bundle
interface if_fetch_if;

    logic [15:0] i_addr;
    logic        i_re;
    logic        i_rdy;
    logic [15:0] instr_in;
    logic [15:0] instr_out;
    logic [15:0] pc_plus1_out;
    logic        valid_out;

    // master: the fetch stage; slave: memory + decode side
    modport master (
        output i_addr, i_re, instr_out, pc_plus1_out, valid_out,
        input  i_rdy, instr_in
    );

    modport slave (
        input  i_addr, i_re, instr_out, pc_plus1_out, valid_out,
        output i_rdy, instr_in
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline boundary register with hold and clear-to-NOP
module if_id_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        clear_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_plus1_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus1_o,
    output logic        valid_o
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus1_q, pc_plus1_d;
    logic        valid_q, valid_d;

    // clear beats hold so a redirect always kills the wrong-path slot
    always_comb begin
        instr_d    = instr_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
        if (clear_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            instr_d    = instr_i;
            pc_plus1_d = pc_plus1_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus1_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus1_o = pc_plus1_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, fetch FSM, IF/ID boundary
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = NOP_INSTR_DEF,
    parameter logic [3:0]  HLT_OPCODE = OP_HLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redir_pc,
    if_fetch_if.master  bus,
    output logic        halted
);

    logic [15:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;
    logic         halted_q, halted_d;
    logic         id_hold, id_clear;
    logic         pending;

    // While a miss is outstanding, a redirect is parked in pc and waits for i_rdy
    assign pending = (state_q == ST_MISS) || (state_q == ST_REDIRECT);

    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        id_hold  = 1'b0;
        id_clear = 1'b0;
        if (flush) begin
            id_clear = 1'b1;
            pc_d     = redir_pc;
            state_d  = (pending && !bus.i_rdy) ? ST_REDIRECT : ST_RUN;
        end else if (stall) begin
            id_hold = 1'b1;
        end else if (state_q == ST_HALTED) begin
            id_clear = 1'b1;
        end else if (!bus.i_rdy) begin
            id_clear = 1'b1;
            if (state_q == ST_RUN) begin
                state_d = ST_MISS;
            end
        end else begin
            pc_d    = pc_q + 16'd1;
            state_d = (opcode_of(bus.instr_in) == HLT_OPCODE) ? ST_HALTED : ST_RUN;
        end
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (id_hold),
        .clear_i    (id_clear),
        .instr_i    (bus.instr_in),
        .pc_plus1_i (pc_q + 16'd1),
        .instr_o    (bus.instr_out),
        .pc_plus1_o (bus.pc_plus1_out),
        .valid_o    (bus.valid_out)
    );

    assign bus.i_addr = pc_q;
    assign bus.i_re   = (state_q != ST_HALTED);
    assign halted     = halted_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for the if_fetch stage
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] redir_pc = 16'h0000;
    logic        halted;

    if_fetch_if bus();

    if_fetch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flush    (flush),
        .redir_pc (redir_pc),
        .bus      (bus),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] ovr [logic [15:0]];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [31:0] h;
        logic [15:0] w;
        if (ovr.exists(a)) return ovr[a];
        h = ({16'h0000, a} * 32'd40503) ^ 32'h0000_1357;
        w = h[15:0];
        if (w[15:12] == 4'hF) w[15:12] = 4'h7;
        return w;
    endfunction

    // Memory answers for the current address; junk when not ready
    assign bus.instr_in = bus.i_rdy ? mem_word(bus.i_addr) : (16'hBAD0 ^ bus.i_addr);

    // Reference: fetch pointer, halt flag and the IF/ID slot
    logic [15:0] m_pc, m_instr, m_pp1;
    logic        m_valid, m_halted, m_pp1_known;

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0; m_pp1_known = 1'b1;
    endtask

    task automatic tick(input logic s, input logic f, input logic [15:0] r, input logic rdy);
        logic [15:0] w;
        stall = s; flush = f; redir_pc = r; bus.i_rdy = rdy;
        @(posedge clk);
        if (f) begin
            m_pc = r; m_instr = 16'h0000; m_valid = 1'b0;
            m_halted = 1'b0; m_pp1_known = 1'b0;
        end else if (s) begin
        end else if (m_halted || !rdy) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            w = mem_word(m_pc);
            m_instr = w; m_pp1 = m_pc + 16'd1; m_valid = 1'b1; m_pp1_known = 1'b1;
            m_halted = (w[15:12] == 4'hF);
            m_pc = m_pc + 16'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; bus.i_rdy = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.i_rdy = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out, halted, bus.i_re, bus.i_addr}
            !== {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_values: got %h/%h/%b/%b/%b/%h required 0000/0000/0/0/1/0000",
                     bus.instr_out, bus.pc_plus1_out, bus.valid_out, halted, bus.i_re, bus.i_addr);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        logic [15:0] tbl [4];
        tbl[0] = 16'h1234; tbl[1] = 16'h2345; tbl[2] = 16'h3456; tbl[3] = 16'h4567;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b1);
            n_vec++;
            if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out} !== {tbl[i], 16'(i + 1), 1'b1}) begin
                n_err++;
                $display("FAIL sequential[%0d]: got %h/%h/%b required %h/%h/1",
                         i, bus.instr_out, bus.pc_plus1_out, bus.valid_out, tbl[i], 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
            n_vec++;
            if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out, bus.i_addr} !== {16'h2345, 16'h0002, 1'b1, 16'h0002}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %h/%h/%b addr %h required 2345/0002/1 addr 0002",
                         i, bus.instr_out, bus.pc_plus1_out, bus.valid_out, bus.i_addr);
            end
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out} !== {16'h3456, 16'h0003}) begin
            n_err++;
            $display("FAIL stall_release: got %h/%h required 3456/0003", bus.instr_out, bus.pc_plus1_out);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out} !== {16'h4567, 16'h0004}) begin
            n_err++;
            $display("FAIL stall_after: got %h/%h required 4567/0004", bus.instr_out, bus.pc_plus1_out);
        end
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b1, 1'b1, 16'h0040, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.valid_out, bus.i_addr} !== {16'h0000, 1'b0, 16'h0040}) begin
            n_err++;
            $display("FAIL flush_stall: got %h/%b addr %h required 0000/0 addr 0040",
                     bus.instr_out, bus.valid_out, bus.i_addr);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out} !== {mem_word(16'h0040), 16'h0041, 1'b1}) begin
            n_err++;
            $display("FAIL flush_target: got %h/%h/%b required %h/0041/1",
                     bus.instr_out, bus.pc_plus1_out, bus.valid_out, mem_word(16'h0040));
        end
    endtask

    task automatic test_miss();
        do_reset();
        repeat (5) tick(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if ({bus.instr_out, bus.valid_out, bus.i_re, bus.i_addr} !== {16'h0000, 1'b0, 1'b1, 16'h0005}) begin
                n_err++;
                $display("FAIL miss_bubble[%0d]: got %h/%b re %b addr %h required 0000/0 re 1 addr 0005",
                         i, bus.instr_out, bus.valid_out, bus.i_re, bus.i_addr);
            end
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out} !== {mem_word(16'h0005), 16'h0006, 1'b1}) begin
            n_err++;
            $display("FAIL miss_resume: got %h/%h/%b required %h/0006/1",
                     bus.instr_out, bus.pc_plus1_out, bus.valid_out, mem_word(16'h0005));
        end
    endtask

    task automatic test_miss_redirect();
        logic [15:0] tgt [4];
        tgt[0] = 16'h0100; tgt[1] = 16'h0100; tgt[2] = 16'h0200; tgt[3] = 16'h0100;
        do_reset();
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, (i != 1), tgt[i], 1'b0);
            n_vec++;
            if ({bus.valid_out, bus.i_re, bus.i_addr} !== {1'b0, 1'b1, tgt[i]}) begin
                n_err++;
                $display("FAIL redirect[%0d]: got valid %b re %b addr %h required 0/1 addr %h",
                         i, bus.valid_out, bus.i_re, bus.i_addr, tgt[i]);
            end
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out} !== {mem_word(16'h0100), 16'h0101, 1'b1}) begin
            n_err++;
            $display("FAIL redirect_data: got %h/%h/%b required %h/0101/1",
                     bus.instr_out, bus.pc_plus1_out, bus.valid_out, mem_word(16'h0100));
        end
    endtask

    task automatic test_halt_wrap();
        do_reset();
        tick(1'b0, 1'b1, 16'hFFFF, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out, halted, bus.i_re, bus.i_addr}
            !== {16'hF000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL halt_fetch: got %h/%h/%b h%b re%b addr %h required F000/0000/1 h1 re0 addr 0000",
                     bus.instr_out, bus.pc_plus1_out, bus.valid_out, halted, bus.i_re, bus.i_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b1);
            n_vec++;
            if ({bus.valid_out, halted, bus.i_re, bus.i_addr} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
                n_err++;
                $display("FAIL halted_hold[%0d]: got v%b h%b re%b addr %h required v0 h1 re0 addr 0000",
                         i, bus.valid_out, halted, bus.i_re, bus.i_addr);
            end
        end
        tick(1'b0, 1'b1, 16'h0010, 1'b0);
        n_vec++;
        if ({bus.valid_out, halted, bus.i_re, bus.i_addr} !== {1'b0, 1'b0, 1'b1, 16'h0010}) begin
            n_err++;
            $display("FAIL halt_exit: got v%b h%b re%b addr %h required v0 h0 re1 addr 0010",
                     bus.valid_out, halted, bus.i_re, bus.i_addr);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out} !== {mem_word(16'h0010), 16'h0011, 1'b1}) begin
            n_err++;
            $display("FAIL halt_resume: got %h/%h/%b required %h/0011/1",
                     bus.instr_out, bus.pc_plus1_out, bus.valid_out, mem_word(16'h0010));
        end
    endtask

    task automatic test_reset_mid_redirect();
        do_reset();
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h0300, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.valid_out, bus.i_addr, halted} !== {1'b0, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got valid %b addr %h halted %b required 0 addr 0000 halted 0",
                     bus.valid_out, bus.i_addr, halted);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if ({bus.instr_out, bus.pc_plus1_out, bus.valid_out} !== {mem_word(16'h0000), 16'h0001, 1'b1}) begin
            n_err++;
            $display("FAIL reset_refetch: got %h/%h/%b required %h/0001/1",
                     bus.instr_out, bus.pc_plus1_out, bus.valid_out, mem_word(16'h0000));
        end
    endtask

    task automatic test_random();
        logic s, f, rdy;
        logic [15:0] r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            r   = 16'($urandom_range(16'h60, 16'h7F));
            tick(s, f, r, rdy);
            n_vec++;
            if ({bus.instr_out, bus.valid_out, halted, bus.i_re, bus.i_addr}
                    !== {m_instr, m_valid, m_halted, !m_halted, m_pc}
                || (m_pp1_known && bus.pc_plus1_out !== m_pp1)) begin
                n_err++;
                $display("FAIL random[%0d]: got %h/%h/%b h%b re%b addr %h required %h/%h/%b h%b re%b addr %h",
                         i, bus.instr_out, bus.pc_plus1_out, bus.valid_out, halted, bus.i_re, bus.i_addr,
                         m_instr, m_pp1, m_valid, m_halted, !m_halted, m_pc);
            end
        end
    endtask

    initial begin
        bus.i_rdy = 1'b0;
        ovr[16'h0000] = 16'h1234;
        ovr[16'h0001] = 16'h2345;
        ovr[16'h0002] = 16'h3456;
        ovr[16'h0003] = 16'h4567;
        ovr[16'hFFFF] = 16'hF000;
        for (int i = 0; i < 6; i++) ovr[16'(16'h60 + $urandom_range(0, 31))] = 16'hF000 | 16'($urandom_range(0, 4095));
        model_reset();

        test_reset();
        test_sequential();
        test_stall();
        test_flush_over_stall();
        test_miss();
        test_miss_redirect();
        test_halt_wrap();
        test_reset_mid_redirect();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
